sha1_digest_serializer: RTL

Downstream stage of `sha1_block`: captures the 160-bit digest when `done` rises and streams it byte-by-byte, MSB first, into a byte-wide UART transmitter through a write/busy handshake. It replaces a 160-bit-wide transmit path with a standard 8-bit serial byte stream. Optionally the digest is sent as printable lowercase hex followed by a newline.

---
 rtl/sha1_digest_serializer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sha1_digest_serializer.sv
// Captures a SHA-1 digest on the rising edge of done and streams it MSB-first over a tx_wr/tx_busy byte
// handshake. Define SHA1_DIGEST_HEX_EN to send lowercase ASCII hex followed by a newline.
module sha1_digest_serializer #(
  parameter int NBYTES = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                done,
  input  logic [8*NBYTES-1:0] context_in,
  input  logic                tx_busy,
  output logic [7:0]          tx_data,
  output logic                tx_wr,
  output logic                busy,
  output logic                sent,
  output logic                overrun
);
`ifdef SHA1_DIGEST_HEX_EN
  localparam int NSYM = 2*NBYTES + 1;
`else
  localparam int NSYM = NBYTES;
`endif
  localparam int IW = $clog2(NSYM + 1);
  localparam int DW = 8*NBYTES;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_ACK = 2'd2, WAIT_DONE = 2'd3} state_t;

  state_t        state_r, state_s;
  logic          done_q_r;
  logic [DW-1:0] shift_r, shift_s;
  logic [IW-1:0] idx_r, idx_s;
  logic [7:0]    tx_data_r, tx_data_s;
  logic          tx_wr_r, tx_wr_s;
  logic          busy_r, busy_s;
  logic          sent_r, sent_s;
  logic          overrun_r, overrun_s;
  logic          cap_s, last_s, shift_adv_s;
  logic [7:0]    sym_s;

  assign cap_s  = done & ~done_q_r;
  assign last_s = (idx_r == IW'(NSYM - 1));

`ifdef SHA1_DIGEST_HEX_EN
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    if (n < 4'd10) nib2hex = 8'h30 + {4'h0, n};
    else           nib2hex = 8'h57 + {4'h0, n};  // 8'h57 + 10 lands on 'a'
  endfunction

  // Symbol selection: high nibble on even index, low nibble on odd, newline as the final symbol
  always_comb begin
    sym_s       = 8'h00;
    shift_adv_s = idx_r[0];
    if (last_s)        sym_s = 8'h0A;
    else if (idx_r[0]) sym_s = nib2hex(shift_r[DW-5 -: 4]);
    else               sym_s = nib2hex(shift_r[DW-1 -: 4]);
  end
`else
  // Symbol selection: the top byte of the shift register, advancing every symbol
  always_comb begin
    sym_s       = shift_r[DW-1 -: 8];
    shift_adv_s = 1'b1;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    idx_s     = idx_r;
    tx_data_s = tx_data_r;
    tx_wr_s   = 1'b0;
    busy_s    = busy_r;
    sent_s    = 1'b0;
    overrun_s = overrun_r | (cap_s & busy_r);
    case (state_r)
      IDLE: begin
        if (cap_s) begin
          shift_s = context_in;
          idx_s   = '0;
          busy_s  = 1'b1;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_wr_s   = 1'b1;
          tx_data_s = sym_s;
          state_s   = WAIT_ACK;
        end else begin
          state_s = SEND;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_s = WAIT_DONE;
        else         state_s = WAIT_ACK;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_s) begin
            sent_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = IDLE;
          end else begin
            idx_s = idx_r + IW'(1);
            if (shift_adv_s) shift_s = shift_r << 8;
            else             shift_s = shift_r;
            state_s = SEND;
          end
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      done_q_r  <= 1'b0;
      shift_r   <= '0;
      idx_r     <= '0;
      tx_data_r <= 8'h00;
      tx_wr_r   <= 1'b0;
      busy_r    <= 1'b0;
      sent_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      done_q_r  <= done;
      shift_r   <= shift_s;
      idx_r     <= idx_s;
      tx_data_r <= tx_data_s;
      tx_wr_r   <= tx_wr_s;
      busy_r    <= busy_s;
      sent_r    <= sent_s;
      overrun_r <= overrun_s;
    end
  end

  assign tx_data = tx_data_r;
  assign tx_wr   = tx_wr_r;
  assign busy    = busy_r;
  assign sent    = sent_r;
  assign overrun = overrun_r;
endmodule
